cla_adder_pipe: RTL and testbench
=================================

# cla_adder_pipe

Parametrised, two-stage pipelined carry-lookahead adder/subtractor with a valid/ready stream interface. It generalises the 4-bit group generate/propagate cell to an arbitrary multiple-of-group width. It adds a subtract mode, status flags and registered stages with backpressure. It sits in the datapath as the shared add/sub unit feeding downstream ALU/accumulator stages.

## Interface

- WIDTH, 16, operand width in bits; must be a multiple of GROUP and ≥ GROUP
- GROUP, 4, bits per lookahead group; number of groups NG = WIDTH/GROUP

Ports:

- i_clk  input  1  clock, rising-edge
- i_rst  input  1  reset, asynchronous, active-high
- i_valid  input  1  input operation present
- o_ready  output  1  block accepts input this cycle
- i_a  input  WIDTH  operand A
- i_b  input  WIDTH  operand B
- i_cin  input  1  carry-in (add mode only)
- i_sub  input  1  1 = A − B, 0 = A + B + i_cin
- o_valid  output  1  result present
- i_ready  input  1  downstream accepts result
- o_sum  output  WIDTH  result
- o_cout  output  1  carry-out of MSB (sub: 1 = no borrow)
- o_ovf  output  1  signed overflow
- o_zero  output  1  o_sum == 0

## Operation

- Effective operands: b_eff = i_sub ? ~i_b : i_b. c0 = i_sub ? 1 : i_cin (i_cin ignored when i_sub = 1).
- Stage 1 (S1), registered:
  - per-bit p = a ^ b_eff and g = a & b_eff;
  - per-group G/P: G = g[k-1] | p[k-1]&(g[k-2] | …), P = AND of all p in the group;
  - c0 and a valid bit v1.
- Stage 2 (S2), registered:
  - group carries c_grp[j+1] = G[j] | P[j]&c_grp[j], with c_grp[0] = c0;
  - in-group carries from the S1 bit g/p, then sum = p ^ carry;
  - o_cout = carry out of bit WIDTH−1;
  - o_ovf = carry into bit WIDTH−1 XOR o_cout;
  - o_zero = (sum == 0);
  - valid bit v2 = o_valid.
- Arithmetic is modulo 2^WIDTH. The result equals A + b_eff + c0 exactly.
- Pipeline enable: en = !o_valid | i_ready; o_ready = en.
  - When en = 1, both stages advance: S1 ← input (v1 ← i_valid), S2 ← S1 (v2 ← v1).
  - When en = 0, all stage registers hold.
- Transfers:
  - an input is accepted when i_valid & o_ready;
  - an output is consumed when o_valid & i_ready.
- Bubbles: an invalid S1 entry (v1 = 0) produces o_valid = 0 when it reaches S2. Bubbles are not squeezed while stalled.
- Data registers of invalid entries are don't-care internally, but outputs are gated: o_sum, o_cout, o_ovf and o_zero are 0 whenever o_valid = 0.
- No state machine beyond the two valid bits.

## Timing

- Reset (async assert, sync deassert handled upstream):
  - v1 = v2 = 0 and all data registers cleared immediately;
  - o_valid = 0, o_sum = 0, o_cout = o_ovf = o_zero = 0;
  - o_ready = 1 from the first cycle after reset.
- Latency: an op accepted at edge N appears on the outputs after edge N+1 (2 edges, registered outputs). There is no combinational path from i_a, i_b or i_sub to the outputs.
- Throughput: one op per cycle while i_ready = 1.
- Stall:
  - o_valid = 1 & i_ready = 0 forces o_ready = 0 in the same cycle (combinational from i_ready and v2);
  - outputs stay stable until consumed.
- Simultaneous consume and accept: when i_ready = 1 and i_valid = 1 with the pipe full, the op in S2 is consumed, S1 moves to S2 and the new op enters S1. No loss or duplication.
- Reset mid-operation: all in-flight ops are discarded. None emerge after release.
- i_valid may drop at any time. Data with i_valid = 0 never produces o_valid.

## Test plan

- Add, WIDTH = 16: A = 0x00FF, B = 0x0001, cin = 0, sub = 0 -> two edges later o_sum = 0x0100, cout = 0, ovf = 0, zero = 0.
- Overflow and wrap:
  - 0x7FFF + 0x0001 -> 0x8000, ovf = 1, cout = 0;
  - 0xFFFF + 0x0001 with cin = 1 -> 0x0001, cout = 1, ovf = 0.
- Subtract:
  - 0x0005 − 0x0007 -> 0xFFFE, cout = 0, ovf = 0;
  - 0x1234 − 0x1234 -> 0x0000, zero = 1, cout = 1;
  - 0x8000 − 0x0001 -> 0x7FFF, ovf = 1.
- Backpressure: stream ops 1 + 1, 2 + 2, 3 + 3 back-to-back and hold i_ready = 0 for 3 cycles after the first result -> o_ready = 0 during the stall, o_sum held at 0x0002, then 0x0004 and 0x0006 in order with no gaps once i_ready = 1.
- Reset mid-flight: accept two ops, assert i_rst for 1 cycle -> o_valid = 0 and o_sum = 0 immediately. No result appears in the 5 cycles after release, and o_ready = 1.
- Randomised sweep at WIDTH = 32, GROUP = 4 and WIDTH = 8, GROUP = 8 -> every result matches the reference model A + b_eff + c0 and its flags. Valid count in equals valid count out.

Source files
------------

// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Stage 1 forms bit and group generate/propagate terms; stage 2 resolves carries and flags.
module cla_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf,
    output logic             o_zero
);

    localparam int NG = WIDTH / GROUP;

    // Group generate: ripple the generate term across the group from LSB upwards.
    function automatic logic grp_gen(input logic [GROUP-1:0] g, input logic [GROUP-1:0] p);
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < GROUP; k++) begin
            acc = g[k] | (p[k] & acc);
        end
        return acc;
    endfunction

    function automatic logic grp_prop(input logic [GROUP-1:0] p);
        return &p;
    endfunction

    logic             en_s;
    logic [WIDTH-1:0] b_eff_s;
    logic [WIDTH-1:0] p_s;
    logic [WIDTH-1:0] g_s;
    logic             c0_s;
    logic [NG-1:0]    grp_g_s;
    logic [NG-1:0]    grp_p_s;

    logic             v1_r;
    logic             c0_r;
    logic [WIDTH-1:0] p1_r;
    logic [WIDTH-1:0] g1_r;
    logic [NG-1:0]    grp_g1_r;
    logic [NG-1:0]    grp_p1_r;

    logic [WIDTH-1:0] carry_s;
    logic [WIDTH-1:0] sum_s;
    logic             cout_s;
    logic             ovf_s;
    logic             zero_s;

    logic             v2_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic             zero_r;

    // Both stages advance together whenever the output slot is free or being drained.
    assign en_s    = ~v2_r | i_ready;
    assign o_ready = en_s;

    // Stage 1 combinational: effective operands, bit and group generate/propagate.
    always_comb begin
        if (i_sub) begin
            b_eff_s = ~i_b;
            c0_s    = 1'b1;
        end else begin
            b_eff_s = i_b;
            c0_s    = i_cin;
        end
        p_s     = i_a ^ b_eff_s;
        g_s     = i_a & b_eff_s;
        grp_g_s = '0;
        grp_p_s = '0;
        for (int j = 0; j < NG; j++) begin
            grp_g_s[j] = grp_gen(g_s[j*GROUP +: GROUP], p_s[j*GROUP +: GROUP]);
            grp_p_s[j] = grp_prop(p_s[j*GROUP +: GROUP]);
        end
    end

    // Stage 1 register: captures terms and the carry-in of the accepted operation.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v1_r     <= 1'b0;
            c0_r     <= 1'b0;
            p1_r     <= '0;
            g1_r     <= '0;
            grp_g1_r <= '0;
            grp_p1_r <= '0;
        end else if (en_s) begin
            v1_r     <= i_valid;
            c0_r     <= c0_s;
            p1_r     <= p_s;
            g1_r     <= g_s;
            grp_g1_r <= grp_g_s;
            grp_p1_r <= grp_p_s;
        end
    end

    // Stage 2 combinational: lookahead group carries, in-group carries, sum and flags.
    always_comb begin
        logic [NG:0] cg;
        logic        c;
        cg      = '0;
        c       = 1'b0;
        carry_s = '0;
        cg[0]   = c0_r;
        for (int j = 0; j < NG; j++) begin
            cg[j+1] = grp_g1_r[j] | (grp_p1_r[j] & cg[j]);
        end
        for (int j = 0; j < NG; j++) begin
            c = cg[j];
            for (int k = 0; k < GROUP; k++) begin
                carry_s[j*GROUP+k] = c;
                c = g1_r[j*GROUP+k] | (p1_r[j*GROUP+k] & c);
            end
        end
        sum_s  = p1_r ^ carry_s;
        cout_s = cg[NG];
        ovf_s  = carry_s[WIDTH-1] ^ cg[NG];
        zero_s = (sum_s == '0);
    end

    // Stage 2 register: results of bubbles are stored as zero so outputs need no gating logic.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v2_r   <= 1'b0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else if (en_s) begin
            v2_r   <= v1_r;
            sum_r  <= v1_r ? sum_s  : '0;
            cout_r <= v1_r ? cout_s : 1'b0;
            ovf_r  <= v1_r ? ovf_s  : 1'b0;
            zero_r <= v1_r ? zero_s : 1'b0;
        end
    end

    assign o_valid = v2_r;
    assign o_sum   = sum_r;
    assign o_cout  = cout_r;
    assign o_ovf   = ovf_r;
    assign o_zero  = zero_r;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Bench for cla_adder_pipe: directed 16-bit vectors, backpressure, reset mid-flight,
// and a scoreboarded sweep on 32/4 and 8/8 instances.
module tb_cla_adder_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        v16, r16, cin16, sub16, ov16, ordy16, cout16, ovf16, z16;
    logic [15:0] a16, b16, s16;
    logic        v32, r32, cin32, sub32, ov32, ordy32, cout32, ovf32, z32;
    logic [31:0] a32, b32, s32;
    logic        v8, r8, cin8, sub8, ov8, ordy8, cout8, ovf8, z8;
    logic [7:0]  a8, b8, s8;

    cla_adder_pipe #(.WIDTH(16), .GROUP(4)) u16 (
        .i_clk(clk), .i_rst(rst), .i_valid(v16), .o_ready(ordy16), .i_a(a16), .i_b(b16),
        .i_cin(cin16), .i_sub(sub16), .o_valid(ov16), .i_ready(r16), .o_sum(s16),
        .o_cout(cout16), .o_ovf(ovf16), .o_zero(z16));

    cla_adder_pipe #(.WIDTH(32), .GROUP(4)) u32 (
        .i_clk(clk), .i_rst(rst), .i_valid(v32), .o_ready(ordy32), .i_a(a32), .i_b(b32),
        .i_cin(cin32), .i_sub(sub32), .o_valid(ov32), .i_ready(r32), .o_sum(s32),
        .o_cout(cout32), .o_ovf(ovf32), .o_zero(z32));

    cla_adder_pipe #(.WIDTH(8), .GROUP(8)) u8 (
        .i_clk(clk), .i_rst(rst), .i_valid(v8), .o_ready(ordy8), .i_a(a8), .i_b(b8),
        .i_cin(cin8), .i_sub(sub8), .o_valid(ov8), .i_ready(r8), .o_sum(s8),
        .o_cout(cout8), .o_ovf(ovf8), .o_zero(z8));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: {zero, ovf, cout} in [34:32], sum zero-extended in [31:0].
    function automatic logic [63:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                           input int w, input logic cin, input logic sub);
        logic [63:0] mask, be, full, s;
        logic        c, o, z;
        mask = (64'd1 << w) - 64'd1;
        be   = sub ? (~{32'd0, b}) & mask : {32'd0, b} & mask;
        full = {32'd0, a} + be + {63'd0, (sub ? 1'b1 : cin)};
        s    = full & mask;
        c    = full[w];
        o    = (a[w-1] == be[w-1]) && (s[w-1] != a[w-1]);
        z    = (s == 64'd0);
        return {29'd0, z, o, c, s[31:0]};
    endfunction

    function automatic logic [63:0] out16();
        return {45'd0, z16, ovf16, cout16, s16};
    endfunction

    task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub, input logic [15:0] es,
                         input logic ec, input logic eo, input logic ez);
        a16 = a; b16 = b; cin16 = cin; sub16 = sub; v16 = 1'b1;
        @(posedge clk); #1;
        v16 = 1'b0;
        @(posedge clk); #1;
        check_eq({tag, "_valid"}, {63'd0, ov16}, 64'd1);
        check_eq(tag, out16(), {45'd0, ez, eo, ec, es});
        @(posedge clk); #1;
    endtask

    logic [63:0] q32[$];
    logic [63:0] q8[$];
    int in32 = 0, out32 = 0, in8 = 0, out8 = 0;

    initial begin
        rst = 1'b1;
        v16 = 1'b0; r16 = 1'b1; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
        v32 = 1'b0; r32 = 1'b1; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0;
        v8  = 1'b0; r8  = 1'b1; a8  = '0; b8  = '0; cin8  = 1'b0; sub8  = 1'b0;
        #2;
        check_eq("rst_valid", {63'd0, ov16}, 64'd0);
        check_eq("rst_outs", out16(), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_ready", {63'd0, ordy16}, 64'd1);

        run16("add_00ff",   16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        run16("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        run16("add_wrap",   16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0);
        run16("sub_neg",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run16("sub_zero",   16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        run16("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        run16("sub_cinign", 16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
        check_eq("idle_valid", {63'd0, ov16}, 64'd0);

        // Backpressure: 1+1, 2+2, 3+3 with a three-cycle stall on the first result.
        a16 = 16'd1; b16 = 16'd1; cin16 = 1'b0; sub16 = 1'b0; v16 = 1'b1;
        @(posedge clk); #1;
        a16 = 16'd2; b16 = 16'd2;
        @(posedge clk); #1;
        check_eq("bp_first", {47'd0, ov16, s16}, {47'd1, 16'h0002});
        r16 = 1'b0; a16 = 16'd3; b16 = 16'd3;
        #1;
        check_eq("bp_ready_low", {63'd0, ordy16}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("bp_hold", {46'd0, ordy16, ov16, s16}, {46'd0, 1'b0, 1'b1, 16'h0002});
        end
        r16 = 1'b1;
        @(posedge clk); #1;
        v16 = 1'b0;
        check_eq("bp_second", {47'd0, ov16, s16}, {47'd1, 16'h0004});
        @(posedge clk); #1;
        check_eq("bp_third", {47'd0, ov16, s16}, {47'd1, 16'h0006});
        @(posedge clk); #1;
        check_eq("bp_drained", {47'd0, ov16, s16}, 64'd0);

        // Reset with two operations in flight.
        a16 = 16'h0010; b16 = 16'h0020; v16 = 1'b1;
        @(posedge clk); #1;
        a16 = 16'h0030; b16 = 16'h0040;
        @(posedge clk); #1;
        v16 = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_imm", {47'd0, ov16, s16}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("post_rst", {46'd0, ordy16, ov16, s16}, {46'd0, 1'b1, 1'b0, 16'h0000});
        end

        // Scoreboarded sweep with random valid/ready on the 32/4 and 8/8 instances.
        for (int i = 0; i < 410; i++) begin
            if (i < 400) begin
                v32 = ($urandom_range(3) != 0); r32 = ($urandom_range(3) != 0);
                a32 = $urandom; b32 = $urandom;
                cin32 = 1'($urandom_range(1)); sub32 = 1'($urandom_range(1));
                v8 = ($urandom_range(3) != 0); r8 = ($urandom_range(3) != 0);
                a8 = 8'($urandom); b8 = 8'($urandom);
                cin8 = 1'($urandom_range(1)); sub8 = 1'($urandom_range(1));
            end else begin
                v32 = 1'b0; r32 = 1'b1; v8 = 1'b0; r8 = 1'b1;
            end
            #1;
            if (ov32 && r32) begin
                out32++;
                if (q32.size() > 0) check_eq("rand32", {29'd0, z32, ovf32, cout32, s32}, q32.pop_front());
            end
            if (!ov32) check_eq("gate32", {29'd0, z32, ovf32, cout32, s32}, 64'd0);
            if (v32 && ordy32) begin
                in32++;
                q32.push_back(ref_op(a32, b32, 32, cin32, sub32));
            end
            if (ov8 && r8) begin
                out8++;
                if (q8.size() > 0) check_eq("rand8", {29'd0, z8, ovf8, cout8, 24'd0, s8}, q8.pop_front());
            end
            if (!ov8) check_eq("gate8", {29'd0, z8, ovf8, cout8, 24'd0, s8}, 64'd0);
            if (v8 && ordy8) begin
                in8++;
                q8.push_back(ref_op({24'd0, a8}, {24'd0, b8}, 8, cin8, sub8));
            end
            @(posedge clk); #1;
        end
        check_eq("count32", 64'(out32), 64'(in32));
        check_eq("count8", 64'(out8), 64'(in8));
        check_eq("q32_empty", 64'(q32.size()), 64'd0);
        check_eq("q8_empty", 64'(q8.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
